// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the RV32E pipeline hazard controller (package hazard_pkg).
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  typedef logic [3:0] regidx_t;

endpackage

// File: rtl/pipeline_hazard_controller_forwarding_unit.sv
// Per-operand register match against EX/MEM/WB destinations; MEM wins over WB.
module forwarding_unit
  import hazard_pkg::*;
#(
  parameter int RIDX_W = 4
) (
  input  logic [RIDX_W-1:0] rs_i,
  input  logic              used_i,
  input  logic              invalid_i,
  input  logic [RIDX_W-1:0] rd_ex_i,
  input  logic [RIDX_W-1:0] rd_mem_i,
  input  logic [RIDX_W-1:0] rd_wb_i,
  input  logic              regwrite_ex_i,
  input  logic              regwrite_mem_i,
  input  logic              regwrite_wb_i,
  output fwd_sel_t          fwd_o,
  output logic              ex_match_o
);

  logic src_live_s;
  logic mem_match_s;
  logic wb_match_s;

  // x0 is hard-wired zero, so reads of it never depend on an older instruction
  assign src_live_s  = used_i && (rs_i != {RIDX_W{1'b0}}) && !invalid_i;
  assign ex_match_o  = src_live_s && regwrite_ex_i  && (rs_i == rd_ex_i);
  assign mem_match_s = src_live_s && regwrite_mem_i && (rs_i == rd_mem_i);
  assign wb_match_s  = src_live_s && regwrite_wb_i  && (rs_i == rd_wb_i);

  always_comb begin
    fwd_o = FWD_NONE;
    if (mem_match_s) begin
      fwd_o = FWD_MEM;
    end else if (wb_match_s) begin
      fwd_o = FWD_WB;
    end else begin
      fwd_o = FWD_NONE;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/redirect/forwarding control for the five-stage RV32E pipeline.
// Operand forwarding is built only when HAZARD_FORWARD_EN is defined.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] rs1_ID,
  input  logic [$clog2(NREGS)-1:0] rs2_ID,
  input  logic                     rs1_used_ID,
  input  logic                     rs2_used_ID,
  input  logic                     invalid_ID,
  input  logic [$clog2(NREGS)-1:0] rd_EX,
  input  logic [$clog2(NREGS)-1:0] rd_MEM,
  input  logic [$clog2(NREGS)-1:0] rd_WB,
  input  logic                     regwrite_EX,
  input  logic                     regwrite_MEM,
  input  logic                     regwrite_WB,
  input  logic                     memread_EX,
  input  logic                     branch_taken_EX,
  input  logic                     imem_ready,
  input  logic                     dmem_req_MEM,
  input  logic                     dmem_ready,
  output logic                     stall_PC,
  output logic                     stall_IF_ID,
  output logic                     stall_ID_EX,
  output logic                     stall_EX_MEM,
  output logic                     stall_MEM_WB,
  output logic                     flush_IF,
  output logic                     flush_ID,
  output logic                     pc_sel,
  output fwd_sel_t                 fwd_a,
  output fwd_sel_t                 fwd_b,
  output logic [CNT_W-1:0]         stall_count
);

  localparam int RIDX_W = $clog2(NREGS);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  fwd_sel_t         fwd_a_s, fwd_b_s;
  logic             ex_match_a_s, ex_match_b_s;
  logic             dwait_entry_s;
  logic             data_wait_s;
  logic             load_use_s;

  forwarding_unit #(.RIDX_W(RIDX_W)) u_fwd_a (
    .rs_i           (rs1_ID),
    .used_i         (rs1_used_ID),
    .invalid_i      (invalid_ID),
    .rd_ex_i        (rd_EX),
    .rd_mem_i       (rd_MEM),
    .rd_wb_i        (rd_WB),
    .regwrite_ex_i  (regwrite_EX),
    .regwrite_mem_i (regwrite_MEM),
    .regwrite_wb_i  (regwrite_WB),
    .fwd_o          (fwd_a_s),
    .ex_match_o     (ex_match_a_s)
  );

  forwarding_unit #(.RIDX_W(RIDX_W)) u_fwd_b (
    .rs_i           (rs2_ID),
    .used_i         (rs2_used_ID),
    .invalid_i      (invalid_ID),
    .rd_ex_i        (rd_EX),
    .rd_mem_i       (rd_MEM),
    .rd_wb_i        (rd_WB),
    .regwrite_ex_i  (regwrite_EX),
    .regwrite_mem_i (regwrite_MEM),
    .regwrite_wb_i  (regwrite_WB),
    .fwd_o          (fwd_b_s),
    .ex_match_o     (ex_match_b_s)
  );

  assign dwait_entry_s = dmem_req_MEM && !dmem_ready;
  // Once in DWAIT the access is outstanding regardless of dmem_req_MEM
  assign data_wait_s   = (state_q == DWAIT) ? !dmem_ready : dwait_entry_s;

`ifdef HAZARD_FORWARD_EN
  logic unused_fwd_s;
  assign unused_fwd_s = 1'b0;
  assign load_use_s   = memread_EX && (ex_match_a_s || ex_match_b_s);
`else
  // Without bypass paths, any in-flight producer in EX or MEM blocks ID
  logic unused_memread_s;
  assign unused_memread_s = memread_EX;
  assign load_use_s = ex_match_a_s || ex_match_b_s ||
                      (fwd_a_s == FWD_MEM) || (fwd_b_s == FWD_MEM);
`endif

  always_comb begin
    state_d      = state_q;
    stall_PC     = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    stall_MEM_WB = 1'b0;
    flush_IF     = 1'b0;
    flush_ID     = 1'b0;
    pc_sel       = 1'b0;
    if (rst) begin
      state_d  = RUN;
      flush_IF = 1'b1;
      flush_ID = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (dwait_entry_s)    state_d = DWAIT;
          else if (!imem_ready) state_d = IWAIT;
          else                  state_d = RUN;
        end
        IWAIT: begin
          if (dwait_entry_s)    state_d = DWAIT;
          else if (imem_ready)  state_d = RUN;
          else                  state_d = IWAIT;
        end
        DWAIT: begin
          if (dmem_ready) state_d = RUN;
          else            state_d = DWAIT;
        end
        default: state_d = RUN;
      endcase

      if (data_wait_s) begin
        stall_PC     = 1'b1;
        stall_IF_ID  = 1'b1;
        stall_ID_EX  = 1'b1;
        stall_EX_MEM = 1'b1;
        stall_MEM_WB = 1'b1;
      end else if (branch_taken_EX) begin
        pc_sel   = 1'b1;
        flush_IF = 1'b1;
        flush_ID = 1'b1;
      end else if (load_use_s || !imem_ready) begin
        stall_PC    = 1'b1;
        stall_IF_ID = 1'b1;
        flush_ID    = 1'b1;
      end else begin
        stall_PC = 1'b0;
      end
    end
  end

  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
`ifdef HAZARD_FORWARD_EN
    if (rst) begin
      fwd_a = FWD_NONE;
      fwd_b = FWD_NONE;
    end else begin
      fwd_a = fwd_a_s;
      fwd_b = fwd_b_s;
    end
`endif
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_PC) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      stall_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector scoreboard bench for pipeline_hazard_controller (both HAZARD_FORWARD_EN builds).
module tb_pipeline_hazard_controller;
  import hazard_pkg::*;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] rs1_ID, rs2_ID, rd_EX, rd_MEM, rd_WB;
  logic       rs1_used_ID, rs2_used_ID, invalid_ID;
  logic       regwrite_EX, regwrite_MEM, regwrite_WB, memread_EX;
  logic       branch_taken_EX, imem_ready, dmem_req_MEM, dmem_ready;
  logic       stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic       flush_IF, flush_ID, pc_sel;
  fwd_sel_t   fwd_a, fwd_b;
  logic [31:0] stall_count;

  pipeline_hazard_controller #(.NREGS(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .invalid_ID(invalid_ID), .rd_EX(rd_EX), .rd_MEM(rd_MEM), .rd_WB(rd_WB),
    .regwrite_EX(regwrite_EX), .regwrite_MEM(regwrite_MEM), .regwrite_WB(regwrite_WB),
    .memread_EX(memread_EX), .branch_taken_EX(branch_taken_EX), .imem_ready(imem_ready),
    .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
    .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
    .flush_IF(flush_IF), .flush_ID(flush_ID), .pc_sel(pc_sel),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] rs1, rs2;
    logic       u1, u2, inv;
    logic [3:0] rde, rdm, rdw;
    logic       we_e, we_m, we_w, memrd, br, imem, dreq, drdy;
  } stim_t;

  typedef struct packed {
    logic [4:0]  st;
    logic        fif, fid, pcs;
    logic [1:0]  fa, fb;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [31:0] acc = 32'd0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.imem = 1'b1;
    return s;
  endfunction

  function automatic exp_t mk(logic [4:0] st, logic fif, logic fid, logic pcs,
                              fwd_sel_t fa, fwd_sel_t fb);
    exp_t e;
    e.st = st; e.fif = fif; e.fid = fid; e.pcs = pcs;
    e.fa = fa; e.fb = fb; e.cnt = 32'd0;
    return e;
  endfunction

  function automatic fwd_sel_t ff(fwd_sel_t x);
    return FWD_EN ? x : FWD_NONE;
  endfunction

  task automatic step(input string nm, input stim_t s, input exp_t e);
    rst = s.rst; rs1_ID = s.rs1; rs2_ID = s.rs2; rs1_used_ID = s.u1; rs2_used_ID = s.u2;
    invalid_ID = s.inv; rd_EX = s.rde; rd_MEM = s.rdm; rd_WB = s.rdw;
    regwrite_EX = s.we_e; regwrite_MEM = s.we_m; regwrite_WB = s.we_w;
    memread_EX = s.memrd; branch_taken_EX = s.br; imem_ready = s.imem;
    dmem_req_MEM = s.dreq; dmem_ready = s.drdy;
    if (s.rst) begin
      e.cnt = 32'd0;
      acc = 32'd0;
    end else begin
      e.cnt = acc;
      acc = acc + {31'd0, e.st[4]};
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per sample
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      logic [4:0] st;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      st = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB};
      checks++;
      if (st !== e.st || flush_IF !== e.fif || flush_ID !== e.fid || pc_sel !== e.pcs ||
          fwd_a !== e.fa || fwd_b !== e.fb) begin
        errors++;
        $display("FAIL %s ctl: got st=%b fif=%b fid=%b pcs=%b fa=%0d fb=%0d, want st=%b fif=%b fid=%b pcs=%b fa=%0d fb=%0d",
                 nm, st, flush_IF, flush_ID, pc_sel, fwd_a, fwd_b,
                 e.st, e.fif, e.fid, e.pcs, e.fa, e.fb);
      end
      checks++;
      if (stall_count !== e.cnt) begin
        errors++;
        $display("FAIL %s cnt: got %0d want %0d", nm, stall_count, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    exp_t  e_run, e_rst, e_dw, e_br, e_lu;
    e_run = mk(5'b00000, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_NONE);
    e_rst = mk(5'b00000, 1'b1, 1'b1, 1'b0, FWD_NONE, FWD_NONE);
    e_dw  = mk(5'b11111, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_NONE);
    e_br  = mk(5'b00000, 1'b1, 1'b1, 1'b1, FWD_NONE, FWD_NONE);
    e_lu  = mk(5'b11000, 1'b0, 1'b1, 1'b0, FWD_NONE, FWD_NONE);

    s = idle(); s.rst = 1'b1;
    rst = 1'b1; rs1_ID = 4'd0; rs2_ID = 4'd0; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
    invalid_ID = 1'b0; rd_EX = 4'd0; rd_MEM = 4'd0; rd_WB = 4'd0;
    regwrite_EX = 1'b0; regwrite_MEM = 1'b0; regwrite_WB = 1'b0; memread_EX = 1'b0;
    branch_taken_EX = 1'b0; imem_ready = 1'b1; dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset dominates even with every hazard source active
    s = idle(); s.rst = 1'b1; s.dreq = 1'b1; s.br = 1'b1; s.memrd = 1'b1;
    s.rde = 4'd5; s.we_e = 1'b1; s.rs1 = 4'd5; s.u1 = 1'b1; s.rdm = 4'd5; s.we_m = 1'b1;
    step("reset_busy", s, e_rst);
    s = idle(); step("idle", s, e_run);

    // Load-use on x5, then it drains through MEM and WB
    s = idle(); s.memrd = 1'b1; s.rde = 4'd5; s.we_e = 1'b1; s.rs1 = 4'd5; s.u1 = 1'b1;
    step("lu_ex", s, e_lu);
    s = idle(); s.rdm = 4'd5; s.we_m = 1'b1; s.rs1 = 4'd5; s.u1 = 1'b1;
    step("lu_mem", s, FWD_EN ? mk(5'b00000, 1'b0, 1'b0, 1'b0, FWD_MEM, FWD_NONE) : e_lu);
    s = idle(); s.rdw = 4'd5; s.we_w = 1'b1; s.rs1 = 4'd5; s.u1 = 1'b1;
    step("lu_wb", s, mk(5'b00000, 1'b0, 1'b0, 1'b0, ff(FWD_WB), FWD_NONE));

    s = idle(); s.rde = 4'd0; s.we_e = 1'b1; s.rs1 = 4'd0; s.u1 = 1'b1; s.rs2 = 4'd0; s.u2 = 1'b1;
    s.rdm = 4'd0; s.we_m = 1'b1;
    step("x0", s, e_run);
    s = idle(); s.inv = 1'b1; s.memrd = 1'b1; s.rde = 4'd5; s.we_e = 1'b1; s.rs1 = 4'd5; s.u1 = 1'b1;
    s.rdm = 4'd5; s.we_m = 1'b1;
    step("invalid_id", s, e_run);
    s = idle(); s.rs1 = 4'd7; s.u1 = 1'b1; s.rs2 = 4'd7; s.u2 = 1'b0;
    s.rdm = 4'd7; s.we_m = 1'b1; s.rdw = 4'd7; s.we_w = 1'b1;
    step("mem_over_wb", s, FWD_EN ? mk(5'b00000, 1'b0, 1'b0, 1'b0, FWD_MEM, FWD_NONE) : e_lu);
    s = idle(); s.rs2 = 4'd9; s.u2 = 1'b1; s.rdm = 4'd9; s.we_m = 1'b0; s.rdw = 4'd9; s.we_w = 1'b1;
    step("wb_rs2", s, mk(5'b00000, 1'b0, 1'b0, 1'b0, FWD_NONE, ff(FWD_WB)));

    s = idle(); s.br = 1'b1; s.memrd = 1'b1; s.rde = 4'd5; s.we_e = 1'b1; s.rs1 = 4'd5; s.u1 = 1'b1;
    step("br_over_lu", s, e_br);

    // Instruction wait, redirect inside IWAIT, then release
    s = idle(); s.imem = 1'b0; step("iwait1", s, e_lu);
    s = idle(); s.imem = 1'b0; step("iwait2", s, e_lu);
    s = idle(); s.imem = 1'b0; s.br = 1'b1; step("iwait_br", s, e_br);
    s = idle(); step("iwait_done", s, e_run);

    // Data wait of three cycles; a redirect is held off meanwhile
    s = idle(); s.dreq = 1'b1; step("dw1", s, e_dw);
    s = idle(); s.dreq = 1'b1; s.br = 1'b1; s.imem = 1'b0; step("dw2_br", s, e_dw);
    s = idle(); s.dreq = 1'b1; step("dw3", s, e_dw);
    s = idle(); s.dreq = 1'b1; s.drdy = 1'b1; step("dw_done", s, e_run);

    // dmem_ready coinciding with a load-use hazard
    s = idle(); s.dreq = 1'b1; step("dw_hz1", s, e_dw);
    s = idle(); s.dreq = 1'b1; s.drdy = 1'b1; s.memrd = 1'b1; s.rde = 4'd6; s.we_e = 1'b1;
    s.rs2 = 4'd6; s.u2 = 1'b1;
    step("dw_hz_lu", s, e_lu);

    // Reset in the middle of DWAIT abandons the wait
    s = idle(); s.dreq = 1'b1; step("dw_rst1", s, e_dw);
    s = idle(); s.dreq = 1'b1; step("dw_rst2", s, e_dw);
    s = idle(); s.rst = 1'b1; s.dreq = 1'b1; step("dw_rst", s, e_rst);
    s = idle(); step("after_rst", s, e_run);

    // ALU producer of x3 travelling EX -> MEM -> WB
    s = idle(); s.rde = 4'd3; s.we_e = 1'b1; s.rs2 = 4'd3; s.u2 = 1'b1;
    step("alu_ex", s, FWD_EN ? e_run : e_lu);
    s = idle(); s.rdm = 4'd3; s.we_m = 1'b1; s.rs2 = 4'd3; s.u2 = 1'b1;
    step("alu_mem", s, FWD_EN ? mk(5'b00000, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_MEM) : e_lu);
    s = idle(); s.rdw = 4'd3; s.we_w = 1'b1; s.rs2 = 4'd3; s.u2 = 1'b1;
    step("alu_wb", s, mk(5'b00000, 1'b0, 1'b0, 1'b0, FWD_NONE, ff(FWD_WB)));

    s = idle(); s.rs1 = 4'd4; s.u1 = 1'b1; s.rs2 = 4'd6; s.u2 = 1'b1;
    s.rdm = 4'd4; s.we_m = 1'b1; s.rdw = 4'd6; s.we_w = 1'b1;
    step("both_ops", s, FWD_EN ? mk(5'b00000, 1'b0, 1'b0, 1'b0, FWD_MEM, FWD_WB) : e_lu);
    s = idle(); step("final_idle", s, e_run);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush/forwarding controller for the five-stage RV32E pipeline. Each cycle it examines register-use information from ID, destination information from EX/MEM/WB, the EX-stage branch resolution and the instruction/data memory ready signals. From these it drives the `stall` inputs of the pipeline registers, the invalid-injection (flush) controls, the PC redirect select and the ALU operand forwarding selects. A small FSM tracks memory-wait episodes, and a registered counter accumulates stall cycles for performance monitoring.

## Interface
Parameters:
- `NREGS`, default 16: architectural register count (RV32E); register index width is `$clog2(NREGS)`.
- `CNT_W`, default 32: stall-counter width.

Ports:
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rs1_ID`, `rs2_ID` input 4: source register indices of the instruction in ID.
- `rs1_used_ID`, `rs2_used_ID` input 1: the instruction in ID actually reads that source.
- `invalid_ID` input 1: the ID slot holds a bubble.
- `rd_EX`, `rd_MEM`, `rd_WB` input 4: destination register index in each stage.
- `regwrite_EX`, `regwrite_MEM`, `regwrite_WB` input 1: that stage writes `rd`; each is already qualified by that stage's valid bit.
- `memread_EX` input 1: the instruction in EX is a load.
- `branch_taken_EX` input 1: EX resolved a taken branch or jump.
- `imem_ready` input 1: the instruction fetch completes this cycle.
- `dmem_req_MEM` input 1: MEM holds a load or store.
- `dmem_ready` input 1: the data access completes this cycle.
- `stall_PC`, `stall_IF_ID`, `stall_ID_EX`, `stall_EX_MEM`, `stall_MEM_WB` output 1: hold the corresponding register.
- `flush_IF` output 1: force `invalid_IF` into IF/ID.
- `flush_ID` output 1: force invalid into ID/EX (bubble).
- `pc_sel` output 1: 1 selects `branch_target`, 0 selects `pc4`.
- `fwd_a`, `fwd_b` output 2: operand source select (`FWD_NONE`, `FWD_MEM`, `FWD_WB`).
- `stall_count` output CNT_W: cycles in which `stall_PC` was asserted.

## Operation
- Hazard match: a hazard exists only when `rsN_used_ID` is set, `rsN != 0`, `invalid_ID` is clear, and a matching `rd` has its regwrite set.
- FSM states are `RUN`, `IWAIT` and `DWAIT`.
- `RUN` → `DWAIT` when `dmem_req_MEM && !dmem_ready`. `DWAIT` → `RUN` on `dmem_ready`.
- `RUN` → `IWAIT` when `!imem_ready` and there is no data wait. `IWAIT` → `RUN` on `imem_ready`.
- Priority, highest first: data wait, then redirect, then load-use, then instruction wait.
  - Data wait (in `DWAIT`, or the entry cycle): all `stall_*` are 1, no flushes, and `pc_sel` is 0. A pending redirect is retained naturally because EX is frozen.
  - Redirect (`branch_taken_EX`): `pc_sel` = 1, `flush_IF` = 1, `flush_ID` = 1, no stalls. This overrides load-use because the ID instruction is discarded.
  - Load-use (`memread_EX` and an rs match on `rd_EX`): `stall_PC` = 1, `stall_IF_ID` = 1, `flush_ID` = 1, held for exactly one cycle.
  - Instruction wait: `stall_PC` = 1, `stall_IF_ID` = 1, `flush_ID` = 1.
- Forwarding select: the MEM stage has priority over WB. `fwd_x` is set to `FWD_MEM` when there is a MEM match, otherwise `FWD_WB` on a WB match, otherwise `FWD_NONE`.
- `stall_count` increments by 1 in each cycle where `stall_PC` is 1 and wraps modulo 2^CNT_W.

## Timing
- All control outputs are combinational from state and inputs within the same cycle. The pipeline registers sample them at the next edge.
- `state` and `stall_count` are registered.
- Load-use penalty: 1 cycle. Redirect penalty: 2 bubbles. Data wait: (cycles until `dmem_ready`) stall cycles.
- Simultaneous `dmem_ready` and a new hazard: return to `RUN`, and the hazard is evaluated in that same cycle.
- During and after reset:
  - While `rst` is high: state is `RUN`, `stall_count` is 0, all stalls are 0, `flush_IF` = 1, `flush_ID` = 1, `pc_sel` = 0, and `fwd_a` = `fwd_b` = `FWD_NONE`.
  - A reset during `DWAIT` abandons the wait immediately.
- WB-to-ID is not a hazard, because the register file bypasses a same-cycle write.

## Configuration
- `HAZARD_FORWARD_EN` defined: behaviour is exactly as described above.
- `HAZARD_FORWARD_EN` undefined:
  - `fwd_a` and `fwd_b` are tied to `FWD_NONE`.
  - Any rs match with EX or MEM (load or not) is treated as a load-use stall.
  - The stall repeats every cycle until the producing instruction reaches WB.
  - Maximum penalty: 2 cycles.

## Structure
- Package `hazard_pkg` holds:
  - `hz_state_t` enum (`RUN`, `IWAIT`, `DWAIT`);
  - `fwd_sel_t` enum (`FWD_NONE`=0, `FWD_MEM`=1, `FWD_WB`=2);
  - `regidx_t` (`logic [3:0]`).
- Sub-module `forwarding_unit` contains the pure match logic and is instantiated twice, once per operand. Its outputs are the `fwd_sel_t` value and an EX-match flag.

## Test plan
- Load writes x5 in EX while the ID instruction uses rs1=x5: 1 cycle with `stall_PC`/`stall_IF_ID`/`flush_ID` = 1. The next cycle gives `fwd_a` = `FWD_MEM`, and `stall_count` increases by 1.
- An ALU op writes x0 in EX while ID reads x0: no stall, and `fwd_a` = `FWD_NONE`.
- `branch_taken_EX` = 1 together with a load-use match: `pc_sel` = 1, `flush_IF` = `flush_ID` = 1, and no stall.
- `dmem_req_MEM` = 1 with `dmem_ready` low for 3 cycles: all stalls are held for 3 cycles with state `DWAIT`, then the FSM returns to `RUN` and `stall_count` increases by 3.
- `rst` is asserted during `DWAIT`: the outputs take their reset values in the same cycle and `stall_count` = 0.
- Without `HAZARD_FORWARD_EN`, an ALU write to x3 in EX with ID reading x3: 2 stall cycles, and `fwd_b` stays `FWD_NONE`.
